// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_pkg;

    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU/REM/REMU unit: 32 iterations, one sign-fix cycle,
// and a one-cycle write-back request. Zero divisor and signed overflow short-cut to DONE.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    input  logic            kill,
    output logic            busy,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    div_state_e      state_q, state_d;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic            busy_d;
    logic            wb_we_d;

    // Request decode and operand conditioning
    div_op_e         op_e;
    logic            accept;
    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            fast;
    logic [XLEN-1:0] fast_res;
    logic [4:0]      rd_eff;

    always_comb begin
        op_e      = div_op_e'(op);
        accept    = (state_q == IDLE) && start && !kill;
        is_signed = (op_e == DIV) || (op_e == REM);
        is_rem    = (op_e == REM) || (op_e == REMU);
        a_neg     = is_signed && rs1_val[XLEN-1];
        b_neg     = is_signed && rs2_val[XLEN-1];
        a_mag     = a_neg ? XLEN'(~rs1_val + XLEN'(1)) : rs1_val;
        b_mag     = b_neg ? XLEN'(~rs2_val + XLEN'(1)) : rs2_val;
        div_zero  = (rs2_val == '0);
        overflow  = is_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                              && (rs2_val == {XLEN{1'b1}});
        fast      = div_zero || overflow;
        if (div_zero) begin
            fast_res = is_rem ? rs1_val : {XLEN{1'b1}};
        end else begin
            fast_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        rd_eff    = accept ? rd : wb_rd;
    end

    // One restoring iteration and the final sign correction
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] result;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, divisor_q};
        quo_fix = neg_quo_q ? XLEN'(~quo_q + XLEN'(1)) : quo_q;
        rem_fix = neg_rem_q ? XLEN'(~rem_q + XLEN'(1)) : rem_q;
        result  = is_rem_q ? rem_fix : quo_fix;
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            wb_we   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            wb_we   <= wb_we_d;
        end
    end

    // Next-state logic; kill overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = fast ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
        end
    end

    // Output decode from the upcoming state
    always_comb begin
        busy_d  = 1'b0;
        wb_we_d = 1'b0;
        busy_d  = (state_d != IDLE);
        wb_we_d = (state_d == DONE) && (rd_eff != 5'd0);
    end

    // Iteration datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            wb_rd     <= 5'd0;
            wb_data   <= '0;
        end else if (accept) begin
            is_rem_q  <= is_rem;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            divisor_q <= b_mag;
            rem_q     <= '0;
            quo_q     <= a_mag;
            cnt_q     <= '0;
            wb_rd     <= rd;
            if (fast) begin
                wb_data <= fast_res;
            end
        end else if (!kill && state_q == CALC) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (!kill && state_q == FIX) begin
            wb_data <= result;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, fast paths,
// ignored start, rd=0, mid-op reset and kill.
module tb_div_unit;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        kill;
    logic        busy;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .kill(kill),
        .busy(busy), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for IDLE at a falling edge, then hold start for one rising edge.
    // Returns in cycle 1 (1 time unit after the accepting edge).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output logic we_c0);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            $display("FAIL idle_timeout busy=%b required 0", busy);
            errors++;
        end
        op = o; rs1_val = a; rs2_val = b; rd = r; start = 1'b1;
        we_c0 = wb_we;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run one op and observe outputs in cycle cyc and the wb_we OR of all cycles before it.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int cyc,
                          output logic we_before, output logic we_at,
                          output logic [31:0] data, output logic [4:0] rdo);
        logic w0;
        issue(o, a, b, r, w0);
        we_before = w0;
        for (int i = 1; i < cyc; i++) begin
            we_before = we_before | wb_we;
            @(posedge clk);
            #1;
        end
        we_at = wb_we;
        data  = wb_data;
        rdo   = wb_rd;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)     begin $display("FAIL reset_busy got %b req 0", busy); errors++; end
        checks++; if (wb_we !== 1'b0)    begin $display("FAIL reset_we got %b req 0", wb_we); errors++; end
        checks++; if (wb_rd !== 5'd0)    begin $display("FAIL reset_rd got %0d req 0", wb_rd); errors++; end
        checks++; if (wb_data !== 32'd0) begin $display("FAIL reset_data got %h req 0", wb_data); errors++; end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu_remu();
        logic wb4, wa; logic [31:0] d; logic [4:0] r;
        run_op(DIVU, 32'd100, 32'd7, 5'd5, 34, wb4, wa, d, r);
        checks++; if (wb4 !== 1'b0)   begin $display("FAIL divu_early_we got %b req 0", wb4); errors++; end
        checks++; if (wa !== 1'b1)    begin $display("FAIL divu_we_c34 got %b req 1", wa); errors++; end
        checks++; if (d !== 32'd14)   begin $display("FAIL divu_data got %h req %h", d, 32'd14); errors++; end
        checks++; if (r !== 5'd5)     begin $display("FAIL divu_rd got %0d req 5", r); errors++; end
        @(posedge clk); #1;
        checks++; if (wb_we !== 1'b0) begin $display("FAIL divu_we_c35 got %b req 0", wb_we); errors++; end
        checks++; if (busy !== 1'b0)  begin $display("FAIL divu_busy_c35 got %b req 0", busy); errors++; end
        run_op(REMU, 32'd100, 32'd7, 5'd6, 34, wb4, wa, d, r);
        checks++; if (wa !== 1'b1)    begin $display("FAIL remu_we_c34 got %b req 1", wa); errors++; end
        checks++; if (d !== 32'd2)    begin $display("FAIL remu_data got %h req %h", d, 32'd2); errors++; end
    endtask

    task automatic test_signed();
        logic wb4, wa; logic [31:0] d; logic [4:0] r;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 34, wb4, wa, d, r);
        checks++; if (wa !== 1'b1 || d !== 32'hFFFF_FFFD) begin $display("FAIL div_neg we=%b data=%h req 1/fffffffd", wa, d); errors++; end
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd1, 34, wb4, wa, d, r);
        checks++; if (wa !== 1'b1 || d !== 32'hFFFF_FFFF) begin $display("FAIL rem_neg we=%b data=%h req 1/ffffffff", wa, d); errors++; end
        run_op(DIV, 32'd20, 32'hFFFF_FFFD, 5'd2, 34, wb4, wa, d, r);
        checks++; if (d !== 32'hFFFF_FFFA) begin $display("FAIL div_negdivisor got %h req fffffffa", d); errors++; end
        run_op(REM, 32'd20, 32'hFFFF_FFFD, 5'd2, 34, wb4, wa, d, r);
        checks++; if (d !== 32'd2) begin $display("FAIL rem_negdivisor got %h req 2", d); errors++; end
    endtask

    task automatic test_div_zero();
        logic wb4, wa; logic [31:0] d; logic [4:0] r;
        run_op(DIV, 32'd42, 32'd0, 5'd8, 1, wb4, wa, d, r);
        checks++; if (wa !== 1'b1)          begin $display("FAIL divz_we_c1 got %b req 1", wa); errors++; end
        checks++; if (d !== 32'hFFFF_FFFF)  begin $display("FAIL divz_data got %h req ffffffff", d); errors++; end
        checks++; if (r !== 5'd8)           begin $display("FAIL divz_rd got %0d req 8", r); errors++; end
        @(posedge clk); #1;
        checks++; if (wb_we !== 1'b0 || busy !== 1'b0) begin $display("FAIL divz_c2 we=%b busy=%b req 0/0", wb_we, busy); errors++; end
        run_op(REM, 32'd42, 32'd0, 5'd8, 1, wb4, wa, d, r);
        checks++; if (wa !== 1'b1 || d !== 32'd42) begin $display("FAIL remz we=%b data=%h req 1/2a", wa, d); errors++; end
    endtask

    task automatic test_overflow();
        logic wb4, wa; logic [31:0] d; logic [4:0] r;
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1, wb4, wa, d, r);
        checks++; if (wa !== 1'b1 || d !== 32'h8000_0000) begin $display("FAIL div_ovf we=%b data=%h req 1/80000000", wa, d); errors++; end
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1, wb4, wa, d, r);
        checks++; if (wa !== 1'b1 || d !== 32'd0) begin $display("FAIL rem_ovf we=%b data=%h req 1/0", wa, d); errors++; end
    endtask

    task automatic test_ignored_start();
        logic w0;
        logic early = 1'b0;
        issue(DIVU, 32'd100, 32'd7, 5'd5, w0);
        for (int c = 1; c < 34; c++) begin
            if (c == 10) begin
                op = DIV; rs1_val = 32'd1000; rs2_val = 32'd3; rd = 5'd9; start = 1'b1;
            end
            if (c == 11) start = 1'b0;
            early = early | wb_we;
            @(posedge clk); #1;
        end
        checks++; if (early !== 1'b0)          begin $display("FAIL ign_early_we got %b req 0", early); errors++; end
        checks++; if (wb_we !== 1'b1)          begin $display("FAIL ign_we_c34 got %b req 1", wb_we); errors++; end
        checks++; if (wb_data !== 32'd14)      begin $display("FAIL ign_data got %h req e", wb_data); errors++; end
        checks++; if (wb_rd !== 5'd5)          begin $display("FAIL ign_rd got %0d req 5", wb_rd); errors++; end
    endtask

    task automatic test_rd_zero();
        logic wb4, wa; logic [31:0] d; logic [4:0] r;
        run_op(DIVU, 32'd50, 32'd5, 5'd0, 34, wb4, wa, d, r);
        checks++; if ((wb4 | wa) !== 1'b0) begin $display("FAIL rd0_we got %b req 0", wb4 | wa); errors++; end
        checks++; if (d !== 32'd10)        begin $display("FAIL rd0_data got %h req a", d); errors++; end
        checks++; if (r !== 5'd0)          begin $display("FAIL rd0_rd got %0d req 0", r); errors++; end
    endtask

    task automatic test_reset_mid();
        logic w0;
        issue(DIVU, 32'd100, 32'd7, 5'd3, w0);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || wb_we !== 1'b0) begin $display("FAIL rstmid_ctl busy=%b we=%b req 0/0", busy, wb_we); errors++; end
        checks++; if (wb_data !== 32'd0 || wb_rd !== 5'd0) begin $display("FAIL rstmid_wb data=%h rd=%0d req 0/0", wb_data, wb_rd); errors++; end
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || wb_data !== 32'd0) begin $display("FAIL rstmid_after busy=%b data=%h req 0/0", busy, wb_data); errors++; end
    endtask

    task automatic test_kill();
        logic wb4, wa; logic [31:0] d; logic [4:0] r; logic w0;
        logic seen = 1'b0;
        run_op(DIVU, 32'd1000, 32'd10, 5'd7, 34, wb4, wa, d, r);
        checks++; if (d !== 32'd100) begin $display("FAIL kill_pre_data got %h req 64", d); errors++; end
        issue(DIVU, 32'd9, 32'd3, 5'd4, w0);
        repeat (19) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++; if (busy !== 1'b0) begin $display("FAIL kill_busy got %b req 0", busy); errors++; end
        for (int i = 0; i < 40; i++) begin
            seen = seen | wb_we;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0)       begin $display("FAIL kill_we got %b req 0", seen); errors++; end
        checks++; if (wb_data !== 32'd100) begin $display("FAIL kill_data got %h req 64", wb_data); errors++; end
        // kill wins over start in IDLE
        @(negedge clk);
        op = DIVU; rs1_val = 32'd8; rs2_val = 32'd0; rd = 5'd2; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        checks++; if (busy !== 1'b0 || wb_we !== 1'b0 || wb_data !== 32'd100) begin
            $display("FAIL kill_idle busy=%b we=%b data=%h req 0/0/64", busy, wb_we, wb_data); errors++;
        end
    endtask

    initial begin
        start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd = '0; kill = 1'b0; rst = 1'b1;
        #2;
        test_reset();
        test_divu_remu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignored_start();
        test_rd_zero();
        test_reset_mid();
        test_kill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
